// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU-control stage: select codes, aluOp classes, FSM states
// and funct7 encodings.
package alu_ctrl_pkg;

  localparam int unsigned SEL_W = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [SEL_W-1:0] {
    SEL_AND    = 5'b00000,
    SEL_OR     = 5'b00001,
    SEL_ADD    = 5'b00010,
    SEL_XOR    = 5'b00011,
    SEL_SLL    = 5'b00100,
    SEL_SRL    = 5'b00101,
    SEL_SUB    = 5'b00110,
    SEL_SLT    = 5'b00111,
    SEL_SRA    = 5'b01000,
    SEL_SLTU   = 5'b01001,
    SEL_MUL    = 5'b10000,
    SEL_MULH   = 5'b10001,
    SEL_MULHSU = 5'b10010,
    SEL_MULHU  = 5'b10011,
    SEL_DIV    = 5'b10100,
    SEL_DIVU   = 5'b10101,
    SEL_REM    = 5'b10110,
    SEL_REMU   = 5'b10111
  } alu_sel_e;

  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_MDWAIT = 2'b10
  } state_e;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  // Operations that have a 32-bit *W form on RV64
  function automatic logic sel_w_legal(input alu_sel_e s);
    case (s)
      SEL_ADD, SEL_SUB, SEL_SLL, SEL_SRL, SEL_SRA,
      SEL_MUL, SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic sel_is_div(input alu_sel_e s);
    case (s)
      SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluOp/funct3/funct7/opIsW decode into an ALU select, with
// M-extension classification and an illegal-encoding flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENABLE_M = 1
) (
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_op_is_w,
  output alu_sel_e   o_sel,
  output logic       o_is_muldiv,
  output logic       o_is_div,
  output logic       o_illegal
);

  localparam logic W_EN = (XLEN == 64);
  localparam logic M_EN = (ENABLE_M != 0);

  alu_sel_e w_raw_sel;
  logic     w_raw_md;
  logic     w_raw_ill;
  logic     w_w_ill;
  logic     w_ill;

  // Raw table lookup, before the *W legality filter
  always_comb begin
    w_raw_sel = SEL_ADD;
    w_raw_md  = 1'b0;
    w_raw_ill = 1'b0;
    case (alu_op_e'(i_alu_op))
      OP_MEM:    w_raw_sel = SEL_ADD;
      OP_BRANCH: w_raw_sel = SEL_SUB;
      OP_RTYPE: begin
        case (i_funct7)
          F7_BASE: begin
            case (i_funct3)
              3'b000: w_raw_sel = SEL_ADD;
              3'b001: w_raw_sel = SEL_SLL;
              3'b010: w_raw_sel = SEL_SLT;
              3'b011: w_raw_sel = SEL_SLTU;
              3'b100: w_raw_sel = SEL_XOR;
              3'b101: w_raw_sel = SEL_SRL;
              3'b110: w_raw_sel = SEL_OR;
              3'b111: w_raw_sel = SEL_AND;
            endcase
          end
          F7_ALT: begin
            case (i_funct3)
              3'b000:  w_raw_sel = SEL_SUB;
              3'b101:  w_raw_sel = SEL_SRA;
              default: w_raw_ill = 1'b1;
            endcase
          end
          F7_MULDIV: begin
            if (M_EN) begin
              w_raw_md = 1'b1;
              case (i_funct3)
                3'b000: w_raw_sel = SEL_MUL;
                3'b001: w_raw_sel = SEL_MULH;
                3'b010: w_raw_sel = SEL_MULHSU;
                3'b011: w_raw_sel = SEL_MULHU;
                3'b100: w_raw_sel = SEL_DIV;
                3'b101: w_raw_sel = SEL_DIVU;
                3'b110: w_raw_sel = SEL_REM;
                3'b111: w_raw_sel = SEL_REMU;
              endcase
            end else begin
              w_raw_ill = 1'b1;
            end
          end
          default: w_raw_ill = 1'b1;
        endcase
      end
      OP_ITYPE: begin
        case (i_funct3)
          3'b000: w_raw_sel = SEL_ADD;
          3'b001: w_raw_sel = SEL_SLL;
          3'b010: w_raw_sel = SEL_SLT;
          3'b011: w_raw_sel = SEL_SLTU;
          3'b100: w_raw_sel = SEL_XOR;
          3'b101: w_raw_sel = i_funct7[5] ? SEL_SRA : SEL_SRL;
          3'b110: w_raw_sel = SEL_OR;
          3'b111: w_raw_sel = SEL_AND;
        endcase
      end
    endcase
  end

  assign w_w_ill = W_EN & i_op_is_w & ~w_raw_ill & ~sel_w_legal(w_raw_sel);
  assign w_ill   = w_raw_ill | w_w_ill;

  // Illegal encodings fall back to a plain single-cycle ADD
  assign o_sel       = w_ill ? SEL_ADD : w_raw_sel;
  assign o_illegal   = w_ill;
  assign o_is_muldiv = w_raw_md & ~w_ill;
  assign o_is_div    = w_raw_md & ~w_ill & sel_is_div(w_raw_sel);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU-control stage: decodes one request per accept and
// holds a countdown stall window for multi-cycle MUL/DIV.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ENABLE_M   = 1,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inValid,
  output logic       inReady,
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       opIsW,
  output logic       outValid,
  input  logic       outReady,
  output alu_sel_e   ctrlSignal,
  output logic       ctrlIsW,
  output logic       mdStart,
  output logic       busy,
  output logic       illegal
);

  localparam logic             W_EN    = (XLEN == 64);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  alu_sel_e         r_sel;
  logic             r_is_w;
  logic             r_md_start;
  logic             r_busy;
  logic             r_illegal;

  alu_sel_e         w_sel;
  logic             w_is_muldiv;
  logic             w_is_div;
  logic             w_illegal;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_init;

  alu_ctrl_decode #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .i_alu_op    (aluOp),
    .i_funct3    (funct3),
    .i_funct7    (funct7),
    .i_op_is_w   (opIsW),
    .o_sel       (w_sel),
    .o_is_muldiv (w_is_muldiv),
    .o_is_div    (w_is_div),
    .o_illegal   (w_illegal)
  );

  assign inReady    = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & outReady);
  assign w_accept   = inValid & inReady;
  assign w_cnt_init = w_is_div ? DIV_CNT : MUL_CNT;

  // FSM and output registers; decode is captured on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_sel       <= SEL_ADD;
      r_is_w      <= 1'b0;
      r_md_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      if (w_accept) begin
        r_sel      <= w_sel;
        r_illegal  <= w_illegal;
        r_is_w     <= W_EN & opIsW;
        r_md_start <= w_is_muldiv;
        // A one-cycle M latency skips the wait state entirely
        if (w_is_muldiv && (w_cnt_init != '0)) begin
          r_state     <= ST_MDWAIT;
          r_cnt       <= w_cnt_init;
          r_busy      <= 1'b1;
          r_out_valid <= 1'b0;
        end else begin
          r_state     <= ST_HOLD;
          r_cnt       <= '0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (outReady) begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
            end
          end
          ST_MDWAIT: begin
            if (r_cnt < CNT_W'(2)) begin
              r_state     <= ST_HOLD;
              r_cnt       <= '0;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign outValid   = r_out_valid;
  assign ctrlSignal = r_sel;
  assign ctrlIsW    = r_is_w;
  assign mdStart    = r_md_start;
  assign busy       = r_busy;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: two configurations (RV32+M, RV64 without M),
// scoreboard of expected {sel, illegal, isW} popped on every output handshake.
module tb_alu_ctrl_pipe;

  localparam logic [4:0] S_AND  = 5'b00000, S_OR   = 5'b00001, S_ADD  = 5'b00010;
  localparam logic [4:0] S_XOR  = 5'b00011, S_SLL  = 5'b00100, S_SRL  = 5'b00101;
  localparam logic [4:0] S_SUB  = 5'b00110, S_SLT  = 5'b00111, S_SRA  = 5'b01000;
  localparam logic [4:0] S_SLTU = 5'b01001, S_MULHU = 5'b10011, S_DIV = 5'b10100;
  localparam logic [4:0] S_REMU = 5'b10111;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alu_op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       op_w;
  logic       in_valid  [2];
  logic       out_ready [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic [4:0] sel       [2];
  logic       is_w      [2];
  logic       md_start  [2];
  logic       busy      [2];
  logic       illegal   [2];

  logic [6:0] q0[$];
  logic [6:0] q1[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_out0  = 0;
  int cyc     = 0;

  alu_ctrl_pipe #(.XLEN(32), .ENABLE_M(1), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut0 (
    .clk(clk), .rst(rst), .inValid(in_valid[0]), .inReady(in_ready[0]),
    .aluOp(alu_op), .funct3(f3), .funct7(f7), .opIsW(op_w),
    .outValid(out_valid[0]), .outReady(out_ready[0]), .ctrlSignal(sel[0]),
    .ctrlIsW(is_w[0]), .mdStart(md_start[0]), .busy(busy[0]), .illegal(illegal[0])
  );

  alu_ctrl_pipe #(.XLEN(64), .ENABLE_M(0), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut1 (
    .clk(clk), .rst(rst), .inValid(in_valid[1]), .inReady(in_ready[1]),
    .aluOp(alu_op), .funct3(f3), .funct7(f7), .opIsW(op_w),
    .outValid(out_valid[1]), .outReady(out_ready[1]), .ctrlSignal(sel[1]),
    .ctrlIsW(is_w[1]), .mdStart(md_start[1]), .busy(busy[1]), .illegal(illegal[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request right after a rising edge; returns just after the accepting edge
  task automatic send(input int k, input logic [1:0] op, input logic [2:0] fn3,
                      input logic [6:0] fn7, input logic w, input logic [4:0] esel,
                      input logic eill, input logic ew);
    logic rdy;
    int   n;
    alu_op = op; f3 = fn3; f7 = fn7; op_w = w;
    in_valid[k] = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = in_ready[k];
      if (rdy) begin
        if (k == 0) q0.push_back({esel, eill, ew});
        else        q1.push_back({esel, eill, ew});
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid[k] = 1'b0;
    chk($sformatf("send_accept_dut%0d", k), 32'(rdy), 32'd1);
  endtask

  // Scoreboard: every output handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid[0] && out_ready[0]) begin
        n_out0++;
        chk("sb0_nonempty", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) chk("sb0_out", 32'({sel[0], illegal[0], is_w[0]}), 32'(q0.pop_front()));
      end
      if (out_valid[1] && out_ready[1]) begin
        chk("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) chk("sb1_out", 32'({sel[1], illegal[1], is_w[1]}), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    int c0, o0;
    rst = 1'b1;
    alu_op = 2'b00; f3 = 3'b000; f7 = 7'h00; op_w = 1'b0;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    repeat (2) step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_sel",       32'(sel[k]),       32'(S_ADD));
      chk("rst_is_w",      32'(is_w[k]),      32'd0);
      chk("rst_md_start",  32'(md_start[k]),  32'd0);
      chk("rst_busy",      32'(busy[k]),      32'd0);
      chk("rst_illegal",   32'(illegal[k]),   32'd0);
      chk("rst_in_ready",  32'(in_ready[k]),  32'd1);
    end
    rst = 1'b0;
    step();

    // SUB then ADD, each valid the cycle after accept
    send(0, 2'b10, 3'b000, 7'h20, 1'b0, S_SUB, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_sub_valid", 32'(out_valid[0]), 32'd1);
    chk("t1_sub_sel",   32'(sel[0]),       32'(S_SUB));
    step();
    send(0, 2'b00, 3'b101, 7'h7f, 1'b0, S_ADD, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_add_valid", 32'(out_valid[0]), 32'd1);
    chk("t1_add_sel",   32'(sel[0]),       32'(S_ADD));
    step();

    // Ten back-to-back R-type ops
    c0 = cyc;
    o0 = n_out0;
    send(0, 2'b10, 3'b000, 7'h00, 1'b0, S_ADD,  1'b0, 1'b0);
    send(0, 2'b10, 3'b000, 7'h20, 1'b0, S_SUB,  1'b0, 1'b0);
    send(0, 2'b10, 3'b001, 7'h00, 1'b0, S_SLL,  1'b0, 1'b0);
    send(0, 2'b10, 3'b010, 7'h00, 1'b0, S_SLT,  1'b0, 1'b0);
    send(0, 2'b10, 3'b011, 7'h00, 1'b0, S_SLTU, 1'b0, 1'b0);
    send(0, 2'b10, 3'b100, 7'h00, 1'b0, S_XOR,  1'b0, 1'b0);
    send(0, 2'b10, 3'b101, 7'h00, 1'b0, S_SRL,  1'b0, 1'b0);
    send(0, 2'b10, 3'b101, 7'h20, 1'b0, S_SRA,  1'b0, 1'b0);
    send(0, 2'b10, 3'b110, 7'h00, 1'b0, S_OR,   1'b0, 1'b0);
    send(0, 2'b10, 3'b111, 7'h00, 1'b0, S_AND,  1'b0, 1'b0);
    chk("t2_cycles", 32'(cyc - c0), 32'd10);
    @(negedge clk);
    step();
    chk("t2_outputs", 32'(n_out0 - o0), 32'd10);

    // Consumer stall: outputs frozen and inReady low while outReady=0
    out_ready[0] = 1'b0;
    send(0, 2'b10, 3'b111, 7'h00, 1'b0, S_AND, 1'b0, 1'b0);
    alu_op = 2'b10; f3 = 3'b110; f7 = 7'h00; op_w = 1'b0;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_in_ready",  32'(in_ready[0]),  32'd0);
      chk("t2_stall_out_valid", 32'(out_valid[0]), 32'd1);
      chk("t2_stall_sel",       32'(sel[0]),       32'(S_AND));
      step();
    end
    out_ready[0] = 1'b1;
    send(0, 2'b10, 3'b110, 7'h00, 1'b0, S_OR, 1'b0, 1'b0);
    @(negedge clk);
    step();

    // DIV wait window; a competing request is ignored
    send(0, 2'b10, 3'b100, 7'h01, 1'b0, S_DIV, 1'b0, 1'b0);
    alu_op = 2'b00; f3 = 3'b000; f7 = 7'h00;
    in_valid[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("t3_md_start_c%0d", c),  32'(md_start[0]),  32'(c == 1));
      chk($sformatf("t3_busy_c%0d", c),      32'(busy[0]),      32'(c <= 7));
      chk($sformatf("t3_out_valid_c%0d", c), 32'(out_valid[0]), 32'(c == 8));
      if (c <= 7) chk($sformatf("t3_in_ready_c%0d", c), 32'(in_ready[0]), 32'd0);
      if (c == 7) in_valid[0] = 1'b0;
      step();
    end

    // MULHU with a two-cycle latency
    send(0, 2'b10, 3'b011, 7'h01, 1'b0, S_MULHU, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_mul_md_start", 32'(md_start[0]),  32'd1);
    chk("t3_mul_busy",     32'(busy[0]),      32'd1);
    chk("t3_mul_valid0",   32'(out_valid[0]), 32'd0);
    step();
    @(negedge clk);
    chk("t3_mul_valid1",   32'(out_valid[0]), 32'd1);
    chk("t3_mul_busy1",    32'(busy[0]),      32'd0);
    chk("t3_mul_md_pulse", 32'(md_start[0]),  32'd0);
    step();

    // M op accepted from HOLD right behind an ADD
    send(0, 2'b00, 3'b000, 7'h00, 1'b0, S_ADD,  1'b0, 1'b0);
    send(0, 2'b10, 3'b111, 7'h01, 1'b0, S_REMU, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_hold_md_start", 32'(md_start[0]),  32'd1);
    chk("t3_hold_busy",     32'(busy[0]),      32'd1);
    chk("t3_hold_valid0",   32'(out_valid[0]), 32'd0);
    repeat (7) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_hold_valid8", 32'(out_valid[0]), 32'd1);
    chk("t3_hold_sel",    32'(sel[0]),       32'(S_REMU));
    step();

    // M disabled: MUL encoding is illegal and single-cycle
    send(1, 2'b10, 3'b000, 7'h01, 1'b0, S_ADD, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_nom_valid",    32'(out_valid[1]), 32'd1);
    chk("t4_nom_illegal",  32'(illegal[1]),   32'd1);
    chk("t4_nom_sel",      32'(sel[1]),       32'(S_ADD));
    chk("t4_nom_md_start", 32'(md_start[1]),  32'd0);
    step();
    // RV32 ignores opIsW; assorted decode corners
    send(0, 2'b10, 3'b111, 7'h00, 1'b1, S_AND, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_rv32_is_w", 32'(is_w[0]), 32'd0);
    step();
    send(0, 2'b10, 3'b001, 7'h20, 1'b0, S_ADD, 1'b1, 1'b0);
    send(0, 2'b10, 3'b000, 7'h10, 1'b0, S_ADD, 1'b1, 1'b0);
    send(0, 2'b11, 3'b000, 7'h20, 1'b0, S_ADD, 1'b0, 1'b0);
    send(0, 2'b01, 3'b111, 7'h7f, 1'b0, S_SUB, 1'b0, 1'b0);
    send(0, 2'b11, 3'b101, 7'h20, 1'b0, S_SRA, 1'b0, 1'b0);
    send(0, 2'b11, 3'b101, 7'h00, 1'b0, S_SRL, 1'b0, 1'b0);
    send(0, 2'b11, 3'b011, 7'h00, 1'b0, S_SLTU, 1'b0, 1'b0);
    @(negedge clk);
    step();

    // RV64 *W forms
    send(1, 2'b10, 3'b111, 7'h00, 1'b1, S_ADD, 1'b1, 1'b1);
    send(1, 2'b10, 3'b101, 7'h20, 1'b1, S_SRA, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_sraw_sel",  32'(sel[1]),     32'(S_SRA));
    chk("t5_sraw_is_w", 32'(is_w[1]),    32'd1);
    chk("t5_sraw_ill",  32'(illegal[1]), 32'd0);
    step();
    send(1, 2'b11, 3'b000, 7'h00, 1'b1, S_ADD, 1'b0, 1'b1);
    send(1, 2'b11, 3'b100, 7'h00, 1'b1, S_ADD, 1'b1, 1'b1);
    send(1, 2'b10, 3'b000, 7'h20, 1'b1, S_SUB, 1'b0, 1'b1);
    send(1, 2'b10, 3'b010, 7'h00, 1'b1, S_ADD, 1'b1, 1'b1);
    send(1, 2'b10, 3'b000, 7'h01, 1'b1, S_ADD, 1'b1, 1'b1);
    send(1, 2'b10, 3'b001, 7'h00, 1'b0, S_SLL, 1'b0, 1'b0);
    @(negedge clk);
    step();

    // Reset in the middle of a DIV wait
    send(0, 2'b10, 3'b100, 7'h01, 1'b0, S_DIV, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("t6_rst_busy",      32'(busy[0]),      32'd0);
    chk("t6_rst_md_start",  32'(md_start[0]),  32'd0);
    chk("t6_rst_sel",       32'(sel[0]),       32'(S_ADD));
    q0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_in_ready",  32'(in_ready[0]),  32'd1);
    chk("t6_post_out_valid", 32'(out_valid[0]), 32'd0);
    chk("t6_post_busy",      32'(busy[0]),      32'd0);
    step();
    send(0, 2'b00, 3'b000, 7'h00, 1'b0, S_ADD, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_add_valid",    32'(out_valid[0]), 32'd1);
    chk("t6_add_sel",      32'(sel[0]),       32'(S_ADD));
    chk("t6_add_md_start", 32'(md_start[0]),  32'd0);
    step();

    repeat (3) step();
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
